// File: rtl/reduce_pkg.sv
// reduce_pkg: shared mode encoding and counter width for the reduce_pipe datapath
package reduce_pkg;
    typedef enum logic [1:0] {RED_AND = 2'd0, RED_OR = 2'd1, RED_XOR = 2'd2, RED_FULL = 2'd3} reduce_mode_t;
    localparam int CNT_W = 16;
endpackage

// File: rtl/reduce_core.sv
// reduce_core: combinational cross-channel AND/OR/XOR or full AND reduction
module reduce_core
    import reduce_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int WIDTH = 8
) (
    input  logic [CH_NUM*WIDTH-1:0] data,
    input  reduce_mode_t            mode,
    output logic [WIDTH-1:0]        result
);
    logic [WIDTH-1:0] a, o, x;
    always_comb begin
        a = '1;
        o = '0;
        x = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            a = a & data[k*WIDTH +: WIDTH];
            o = o | data[k*WIDTH +: WIDTH];
            x = x ^ data[k*WIDTH +: WIDTH];
        end
        result = mode == RED_AND ? a :
                 mode == RED_OR  ? o :
                 mode == RED_XOR ? x : WIDTH'(&data);
    end
endmodule

// File: rtl/reduce_pipe.sv
// reduce_pipe: 2-stage valid/ready channel reducer with backpressure
// Define REDUCE_PIPE_CNT_EN to add the saturating out_count handshake counter.
module reduce_pipe
    import reduce_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_NUM*WIDTH-1:0] in_data,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
`ifdef REDUCE_PIPE_CNT_EN
    output logic [CNT_W-1:0]        out_count,
`endif
    output logic [1:0]              out_mode
);
    logic                    v1, adv1, adv2;
    logic [CH_NUM*WIDTH-1:0] d1;
    reduce_mode_t            m1;
    logic [WIDTH-1:0]        res;
    assign adv2 = !out_valid || out_ready;
    assign adv1 = !v1 || adv2;
    assign in_ready = adv1 && !rst;
    reduce_core #(.CH_NUM(CH_NUM), .WIDTH(WIDTH)) u_core (
        .data   (d1),
        .mode   (m1),
        .result (res)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            d1        <= '0;
            m1        <= RED_AND;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv1 && in_valid) begin
                d1 <= in_data;
                m1 <= reduce_mode_t'(in_mode);
            end
            if (adv2) out_valid <= v1;
            // bubbles leave the last result in place rather than clearing it
            if (adv2 && v1) begin
                out_data <= res;
                out_mode <= m1;
            end
        end
    end
`ifdef REDUCE_PIPE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) out_count <= '0;
        else if (out_valid && out_ready && out_count != '1) out_count <= out_count + 1'b1;
    end
`endif
endmodule
